// File: rtl/dac_wr_capture.sv
// DAC write-bus capture: synchronise cs/wr/din, qualify each strobe,
// timestamp it and queue {interval, data} in a fall-through FIFO.
module dac_wr_capture #(
  parameter int DW         = 8,
  parameter int AW         = 4,
  parameter int IW         = 16,
  parameter int MIN_WR_LOW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [IW-1:0] m_intv,
  output logic [15:0]   sample_cnt,
  output logic          ovf,
  output logic          wr_short_err
);

  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOW   = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic          r_cs_s1, r_cs_s2;
  logic          r_wr_s1, r_wr_s2, r_wr_s3;
  logic [DW-1:0] r_din_s1, r_din_s2;

  logic [1:0]    r_state;
  logic [7:0]    r_lowcnt;

  logic [IW-1:0] r_icnt;
  logic          r_first;

  logic [IW+DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;

  logic [15:0]   r_cnt;
  logic          r_ovf, r_err;

  logic          w_rise;
  logic          w_judge;
  logic          w_capture;
  logic          w_short;
  logic [IW-1:0] w_intv;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [IW+DW-1:0] w_head;

  // Bus idles high, so the synchronisers come out of reset at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_wr_s1  <= 1'b1;
      r_wr_s2  <= 1'b1;
      r_wr_s3  <= 1'b1;
      r_din_s1 <= '1;
      r_din_s2 <= '1;
    end else begin
      r_cs_s1  <= cs;
      r_cs_s2  <= r_cs_s1;
      r_wr_s1  <= wr;
      r_wr_s2  <= r_wr_s1;
      r_wr_s3  <= r_wr_s2;
      r_din_s1 <= din;
      r_din_s2 <= r_din_s1;
    end
  end

  assign w_rise    = r_wr_s2 & ~r_wr_s3;
  assign w_judge   = (r_state == S_LOW) && !r_cs_s2 && w_rise;
  assign w_capture = w_judge && (r_lowcnt >= 8'(MIN_WR_LOW));
  assign w_short   = w_judge && (r_lowcnt < 8'(MIN_WR_LOW));

  // cs leaving mid-strobe wins over a coincident rise: no capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lowcnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_wr_s2 && !r_cs_s2) begin
            r_state  <= S_LOW;
            r_lowcnt <= 8'd1;
          end
        end
        S_LOW: begin
          if (r_cs_s2) begin
            r_state <= w_rise ? S_IDLE : S_ABORT;
          end else if (w_rise) begin
            r_state <= S_IDLE;
          end else if (r_lowcnt != 8'hFF) begin
            r_lowcnt <= r_lowcnt + 8'd1;
          end
        end
        S_ABORT: begin
          if (w_rise) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_intv = '0;
    if (!r_first) begin
      w_intv = (r_icnt == '1) ? r_icnt : r_icnt + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icnt  <= '0;
      r_first <= 1'b1;
    end else if (w_capture) begin
      r_icnt  <= '0;
      r_first <= 1'b0;
    end else if (r_icnt != '1) begin
      r_icnt  <= r_icnt + IW'(1);
    end
  end

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign m_valid = (r_count != '0);
  assign w_pop   = m_valid && m_ready;
  assign w_push  = w_capture && (!w_full || w_pop);
  assign w_drop  = w_capture && w_full && !w_pop;

  assign w_head = m_valid ? r_mem[r_rptr] : '0;
  assign m_intv = w_head[IW+DW-1:DW];
  assign m_data = w_head[DW-1:0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_intv, r_din_s2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + (AW+1)'(1);
        (w_pop && !w_push): r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Set events beat a coincident clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_push)   r_cnt <= clr ? 16'd1 : r_cnt + 16'd1;
      else if (clr) r_cnt <= 16'd0;
      if (w_drop)   r_ovf <= 1'b1;
      else if (clr) r_ovf <= 1'b0;
      if (w_short)  r_err <= 1'b1;
      else if (clr) r_err <= 1'b0;
    end
  end

  assign sample_cnt   = r_cnt;
  assign ovf          = r_ovf;
  assign wr_short_err = r_err;

endmodule

// File: tb/tb_dac_wr_capture.sv
// Bench for dac_wr_capture: directed table, corner sequences and
// randomized bus traffic checked against a queue-based model.
module tb_dac_wr_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b1;
  logic        wr = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        clr = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] m_intv;
  logic [15:0] sample_cnt;
  logic        ovf;
  logic        wr_short_err;

  dac_wr_capture #(
    .DW(8), .AW(4), .IW(16), .MIN_WR_LOW(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .din(din),
    .clr(clr), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_intv(m_intv), .sample_cnt(sample_cnt),
    .ovf(ovf), .wr_short_err(wr_short_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;
  bit rnd = 1'b0;
  int ready_pct = 50;

  typedef struct {
    int         due;
    bit         is_short;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] iv;
  } ent_t;

  typedef struct {
    logic [7:0]  d;
    int          low;
    bit          push;
    logic [7:0]  ed;
    logic [15:0] eiv;
    logic [15:0] ecnt;
    bit          eerr;
  } vec_t;

  ev_t  pend[$];
  ent_t mq[$];
  ent_t obs[$];
  int   m_cnt = 0;
  bit   m_ovf = 0;
  bit   m_err = 0;
  bit   m_first = 1;
  int   m_last = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
               nm, cyc, act, exp);
    end
  endtask

  // Reference: each legal strobe whose wr pin rose at cycle c lands
  // in the queue at edge c+3; interval = distance between captures.
  always @(negedge clk) begin : model_p
    ev_t ev;
    bit pop;
    bit full;
    int dd;
    logic [15:0] iv;
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      m_cnt = 0;
      m_ovf = 0;
      m_err = 0;
      m_first = 1;
      m_last = 0;
    end
    chk("model_valid", m_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("model_data", m_data, mq[0].d);
      chk("model_intv", m_intv, mq[0].iv);
    end
    chk("model_cnt", sample_cnt, m_cnt);
    chk("model_ovf", ovf, m_ovf);
    chk("model_err", wr_short_err, m_err);
    if (rst_n) begin
      if (m_valid && m_ready) obs.push_back('{m_data, m_intv});
      pop = (mq.size() > 0) && m_ready;
      full = (mq.size() == 16);
      if (pop) void'(mq.pop_front());
      if (clr) begin
        m_cnt = 0;
        m_ovf = 0;
        m_err = 0;
      end
      while (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        ev = pend.pop_front();
        if (ev.due == cyc + 1) begin
          if (ev.is_short) begin
            m_err = 1;
          end else begin
            dd = ev.due - m_last;
            iv = m_first ? 16'd0 :
                 (dd > 65535) ? 16'hFFFF : 16'(dd);
            m_first = 0;
            m_last = ev.due;
            if (!full || pop) begin
              mq.push_back('{ev.d, iv});
              m_cnt = (m_cnt + 1) % 65536;
            end else begin
              m_ovf = 1;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      m_ready = ($urandom % 100) < ready_pct;
      clr = ($urandom % 60) == 0;
    end else begin
      clr = 1'b0;
    end
  endtask

  task automatic strobe(input logic [7:0] d, input int low,
                        input int hold, output int rc);
    tick();
    din = d;
    tick();
    wr = 1'b0;
    repeat (low) tick();
    wr = 1'b1;
    rc = cyc;
    pend.push_back('{cyc + 3, (low < 3), d});
    repeat (hold) tick();
  endtask

  task automatic abort_wr();
    tick();
    wr = 1'b0;
    tick();
    tick();
    cs = 1'b1;
    tick();
    wr = 1'b1;
    tick();
    tick();
    cs = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_intv"}, m_intv, 0);
    chk({tag, "_cnt"}, sample_cnt, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_err"}, wr_short_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish within 1000000 ns");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    int rc, rc0, rc_last, o, o0, kind;
    vt[0] = '{8'h80, 3, 1'b1, 8'h80, 16'd0,   16'd1, 1'b0};
    vt[1] = '{8'h86, 3, 1'b1, 8'h86, 16'd388, 16'd2, 1'b0};
    vt[2] = '{8'h8C, 3, 1'b1, 8'h8C, 16'd388, 16'd3, 1'b0};
    vt[3] = '{8'h55, 2, 1'b0, 8'h00, 16'd0,   16'd3, 1'b1};

    repeat (2) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cs = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();

    rc0 = 0;
    rc_last = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        while (cyc < rc0 + i * 388 - 2 - vt[i].low) tick();
      end
      o = obs.size();
      strobe(vt[i].d, vt[i].low, 8, rc);
      if (i == 0) rc0 = rc;
      if (vt[i].push) rc_last = rc;
      chk("tbl_push", obs.size() - o, vt[i].push);
      if (vt[i].push && obs.size() > 0) begin
        chk("tbl_data", obs[obs.size()-1].d, vt[i].ed);
        chk("tbl_intv", obs[obs.size()-1].iv, vt[i].eiv);
      end
      chk("tbl_cnt", sample_cnt, vt[i].ecnt);
      chk("tbl_err", wr_short_err, vt[i].eerr);
      chk("tbl_ovf", ovf, 0);
    end

    clr = 1'b1;
    tick();
    chk("clr_err", wr_short_err, 0);
    chk("clr_cnt", sample_cnt, 0);

    o = obs.size();
    abort_wr();
    repeat (4) tick();
    chk("abort_noentry", obs.size() - o, 0);
    chk("abort_noerr", wr_short_err, 0);
    strobe(8'h42, 4, 8, rc);
    chk("post_abort_n", obs.size() - o, 1);
    if (obs.size() > 0) begin
      chk("post_abort_data", obs[obs.size()-1].d, 8'h42);
      chk("post_abort_intv", obs[obs.size()-1].iv, rc - rc_last);
    end
    chk("post_abort_cnt", sample_cnt, 1);

    clr = 1'b1;
    tick();
    m_ready = 1'b0;
    o0 = obs.size();
    for (int k = 1; k <= 17; k++) strobe(8'(k), 3, 2, rc);
    repeat (5) tick();
    chk("ovf_flag", ovf, 1);
    chk("ovf_cnt", sample_cnt, 16);
    chk("ovf_valid", m_valid, 1);
    chk("ovf_head", m_data, 8'h01);
    clr = 1'b1;
    tick();
    chk("ovf_clr", ovf, 0);
    strobe(8'h12, 3, 0, rc);
    tick();
    tick();
    m_ready = 1'b1;
    repeat (30) tick();
    chk("full_pop_ovf", ovf, 0);
    chk("full_pop_cnt", sample_cnt, 1);
    chk("drain_n", obs.size() - o0, 17);
    if (obs.size() - o0 == 17) begin
      for (int k = 0; k < 16; k++)
        chk("drain_data", obs[o0 + k].d, 8'(k + 1));
      chk("drain_last", obs[o0 + 16].d, 8'h12);
    end

    m_ready = 1'b0;
    repeat (2) tick();
    tick();
    din = 8'hA5;
    tick();
    wr = 1'b0;
    repeat (3) tick();
    wr = 1'b1;
    rc = cyc;
    pend.push_back('{rc + 3, 1'b0, 8'hA5});
    tick();
    chk("lat_e1", m_valid, 0);
    tick();
    chk("lat_e2", m_valid, 0);
    tick();
    chk("lat_e3", m_valid, 1);
    chk("lat_data", m_data, 8'hA5);
    din = 8'h00;
    m_ready = 1'b1;
    repeat (4) tick();

    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) strobe(8'hB0 + 8'(k), 3, 2, rc);
    repeat (4) tick();
    chk("pre_rst_valid", m_valid, 1);
    wr = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    wr = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", m_valid, 0);
    strobe(8'h3C, 3, 5, rc);
    chk("first_valid", m_valid, 1);
    chk("first_data", m_data, 8'h3C);
    chk("first_intv", m_intv, 0);
    m_ready = 1'b1;
    repeat (3) tick();

    rnd = 1'b1;
    for (int op = 0; op < 300; op++) begin
      if (op % 60 == 0) begin
        case ((op / 60) % 3)
          0: ready_pct = 10;
          1: ready_pct = 50;
          default: ready_pct = 95;
        endcase
      end
      kind = $urandom % 10;
      if (kind < 6)
        strobe(8'($urandom), 3 + $urandom % 4, 2 + $urandom % 5, rc);
      else if (kind < 8)
        strobe(8'($urandom), 1 + $urandom % 2, 2 + $urandom % 5, rc);
      else
        abort_wr();
    end
    rnd = 1'b0;
    clr = 1'b0;
    m_ready = 1'b1;
    repeat (40) tick();
    chk("end_empty", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
